mul_pipe_sched: RTL and testbench
=================================

# mul_pipe_sched

Round-robin scheduler that shares one pipelined shift-add multiplier (a chain of multiply cells, one multiplier bit per stage) between N_REQ requesters. It arbitrates operand requests, issues at most one operand pair per cycle into the pipe, and carries a requester tag alongside each operation in a delay line. Each product is returned to its requester as a one-cycle response. It sits between the matrix-multiply PE control logic and the multiplier pipe.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH_A, 16: multiplicand width.
- WIDTH_B, 16: multiplier width.
- PIPE_LAT, 16: cycles from pipe_valid to the matching pipe_ready; equals the pipe's stage count.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  grant enable; in-flight work continues when low.
- req  in  N_REQ  per-requester request, level.
- req_a  in  N_REQ*WIDTH_A  multiplicands, requester i at [i*WIDTH_A +: WIDTH_A].
- req_b  in  N_REQ*WIDTH_B  multipliers, requester i at [i*WIDTH_B +: WIDTH_B].
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as the accepted req.
- rsp_valid  out  N_REQ  one-hot response strobe, one cycle.
- rsp_data  out  WIDTH_A+WIDTH_B  product, shared by all requesters, qualified by rsp_valid.
- pipe_valid  out  1  issue strobe to the first pipe stage.
- pipe_multiplicand  out  WIDTH_A+WIDTH_B  zero-extended multiplicand.
- pipe_multiplier  out  WIDTH_B  multiplier.
- pipe_product  in  WIDTH_A+WIDTH_B  product from the last stage.
- pipe_ready  in  1  last-stage valid.
- busy  out  1  any operation issued and not yet responded.
- err  out  1  sticky tag/pipe misalignment flag.

## Operation
- Arbitration: when enable=1, rst=0 and req!=0, grant exactly one requester. Search starts at pointer ptr, ascending with wrap at N_REQ. ptr becomes winner+1 mod N_REQ after each grant. ptr resets to 0. There is no grant when enable=0 or rst=1.
- Issue: on a grant, register the operands. pipe_multiplicand={WIDTH_B zeros, req_a[i]}, pipe_multiplier=req_b[i], pipe_valid=1 for one cycle. With no grant, pipe_valid=0 and the operand registers go to 0.
- Tag line: PIPE_LAT-deep shift register of {valid, index[$clog2(N_REQ)-1:0]}. It is loaded in step with pipe_valid and advances every cycle with no stall.
- Response: when pipe_ready=1 and the tag at the line output is valid, register the result. rsp_valid has the one-hot bit for that tag set, rsp_data=pipe_product. In all other cycles, rsp_valid=0 and rsp_data holds its last value.
- err set (sticky until rst) in either case:
  - pipe_ready=1 while the tag at the line output is invalid;
  - the tag at the line output is valid while pipe_ready=0.
  - In both cases no response is produced for that cycle.
- busy = pipe_valid | any valid tag in the line | any rsp_valid bit.
- Requester contract: hold req and operands until gnt is seen. A requester may re-request in the cycle after its grant.
- Arithmetic: the product is unsigned, WIDTH_A+WIDTH_B bits, with no truncation.

## Timing
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, pipe_valid=0, pipe_multiplicand=0, pipe_multiplier=0, busy=0, err=0, ptr=0, all tags invalid.
- gnt in cycle t → pipe_valid in t+1 → pipe_ready in t+1+PIPE_LAT → rsp_valid in t+2+PIPE_LAT. Default latency is 18.
- Throughput is one grant per cycle. Responses leave in grant order.
- A single continuous requester is granted every cycle, because wrap returns to it when no other requester is active.
- enable falling in cycle t: no gnt from cycle t. Operations already granted complete normally. busy drops in the cycle after the last rsp_valid.
- rst in mid-flight: in the cycle after rst is sampled, all state is at reset values. In-flight tags are discarded. A pipe_ready returning after reset sets err, and the bench must also reset the pipe.
- A response and a new grant in the same cycle are independent, with no interaction.

## Test plan
- Single op: req[1]=1, a=3, b=5 at t → gnt=0010 at t, rsp_valid=0010 at t+18 with rsp_data=15, busy=0 at t+19.
- All four request at t and hold until granted → gnt 0001, 0010, 0100, 1000 in t..t+3. Responses in the same order at t+18..t+21.
- Rotation: req=0101 held → grants alternate 0001/0100 every cycle. After ptr=3, the next grant is 0001.
- Max operands: a=16'hFFFF, b=16'hFFFF → rsp_data=32'hFFFE0001. Also a=0 → 0, and b=0 → 0.
- enable=0 issued mid-burst at t: gnt=0 from t. Earlier grants respond. busy=0 once all are drained. Responses are unchanged.
- Inject pipe_ready with no tag → err=1 and held. Assert rst with 5 ops in flight → no rsp_valid for them, err=0 and busy=0 after reset.

Source files
------------

// File: rtl/mul_pipe_sched.sv
// mul_pipe_sched: round-robin front end for one shared pipelined multiplier.
// Grants at most one requester per cycle. Registers the operand pair into the pipe.
// Carries the requester index down a tag line that is matched against the pipe output.
// Returns each product as a one-cycle, one-hot response.
module mul_pipe_sched #(
    parameter int N_REQ    = 4,
    parameter int WIDTH_A  = 16,
    parameter int WIDTH_B  = 16,
    parameter int PIPE_LAT = 16   // must be >= 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ*WIDTH_A-1:0]     i_req_a,
    input  logic [N_REQ*WIDTH_B-1:0]     i_req_b,
    output logic [N_REQ-1:0]             o_gnt,
    output logic [N_REQ-1:0]             o_rsp_valid,
    output logic [WIDTH_A+WIDTH_B-1:0]   o_rsp_data,
    output logic                         o_pipe_valid,
    output logic [WIDTH_A+WIDTH_B-1:0]   o_pipe_multiplicand,
    output logic [WIDTH_B-1:0]           o_pipe_multiplier,
    input  logic [WIDTH_A+WIDTH_B-1:0]   i_pipe_product,
    input  logic                         i_pipe_ready,
    output logic                         o_busy,
    output logic                         o_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = WIDTH_A + WIDTH_B;

    logic [IW-1:0]               r_ptr;
    logic                        r_pipe_valid;
    logic [PW-1:0]               r_mcand;
    logic [WIDTH_B-1:0]          r_mplier;
    logic [IW-1:0]               r_iss_idx;
    logic [PIPE_LAT-1:0]         r_tag_vld;
    logic [PIPE_LAT-1:0][IW-1:0] r_tag_idx;
    logic [N_REQ-1:0]            r_rsp_valid;
    logic [PW-1:0]               r_rsp_data;
    logic                        r_err;

    logic                        w_any;
    logic [IW-1:0]               w_win;
    logic [IW:0]                 w_sum;
    logic [N_REQ-1:0]            w_gnt;
    logic [IW-1:0]               w_ptr_nxt;
    logic [WIDTH_A-1:0]          w_a;
    logic [WIDTH_B-1:0]          w_b;
    logic                        w_tag_vld;
    logic [IW-1:0]               w_tag_idx;

    // Round-robin search from r_ptr upward with wrap; first active request wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        w_gnt = '0;
        if (i_enable && !i_rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_sum = {1'b0, r_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N_REQ))
                    w_sum = w_sum - (IW+1)'(N_REQ);
                if (!w_any && i_req[w_sum[IW-1:0]]) begin
                    w_any = 1'b1;
                    w_win = w_sum[IW-1:0];
                end
            end
        end
        if (w_any)
            w_gnt = N_REQ'(1) << w_win;
    end

    assign w_ptr_nxt = (w_win == IW'(N_REQ-1)) ? '0 : w_win + 1'b1;
    assign w_a       = i_req_a[w_win*WIDTH_A +: WIDTH_A];
    assign w_b       = i_req_b[w_win*WIDTH_B +: WIDTH_B];

    // Issue stage: capture the winner's operands; operands read as zero when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr        <= '0;
            r_pipe_valid <= 1'b0;
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_iss_idx    <= '0;
        end else begin
            r_pipe_valid <= w_any;
            r_iss_idx    <= w_win;
            if (w_any) begin
                r_ptr    <= w_ptr_nxt;
                r_mcand  <= {{WIDTH_B{1'b0}}, w_a};
                r_mplier <= w_b;
            end else begin
                r_mcand  <= '0;
                r_mplier <= '0;
            end
        end
    end

    // Tag line fed from the issue register so its output lines up with pipe_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_vld <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[PIPE_LAT-2:0], r_pipe_valid};
            r_tag_idx <= {r_tag_idx[PIPE_LAT-2:0], r_iss_idx};
        end
    end

    assign w_tag_vld = r_tag_vld[PIPE_LAT-1];
    assign w_tag_idx = r_tag_idx[PIPE_LAT-1];

    // Response/err: a product is returned only when the pipe and tag line agree.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (i_pipe_ready && w_tag_vld) begin
                r_rsp_valid <= N_REQ'(1) << w_tag_idx;
                r_rsp_data  <= i_pipe_product;
            end
            if (i_pipe_ready != w_tag_vld)
                r_err <= 1'b1;
        end
    end

    assign o_gnt               = w_gnt;
    assign o_rsp_valid         = r_rsp_valid;
    assign o_rsp_data          = r_rsp_data;
    assign o_pipe_valid        = r_pipe_valid;
    assign o_pipe_multiplicand = r_mcand;
    assign o_pipe_multiplier   = r_mplier;
    assign o_busy              = r_pipe_valid | (|r_tag_vld) | (|r_rsp_valid);
    assign o_err               = r_err;

endmodule

// File: tb/tb_mul_pipe_sched.sv
// tb_mul_pipe_sched: directed stimulus with a queue-based scoreboard.
// The bench also stands in for the multiplier pipe.
module tb_mul_pipe_sched;

    localparam int N = 4, WA = 16, WB = 16, L = 16, W = WA + WB, LAT = L + 2;

    logic            clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*WA-1:0] ra = '0;
    logic [N*WB-1:0] rb = '0;
    logic [N-1:0]    o_gnt, o_rsp_valid;
    logic [W-1:0]    o_rsp_data, o_pipe_mc, pipe_product;
    logic [WB-1:0]   o_pipe_mp;
    logic            o_pipe_valid, o_busy, o_err, pipe_ready;
    logic            inj_ready = 1'b0, inj_drop = 1'b0, chk_on = 1'b0;

    mul_pipe_sched #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .PIPE_LAT(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_req(req),
        .i_req_a(ra), .i_req_b(rb), .o_gnt(o_gnt),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_pipe_valid(o_pipe_valid), .o_pipe_multiplicand(o_pipe_mc),
        .o_pipe_multiplier(o_pipe_mp), .i_pipe_product(pipe_product),
        .i_pipe_ready(pipe_ready), .o_busy(o_busy), .o_err(o_err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier pipe, L cycles deep, cleared together with the DUT.
    logic [L-1:0] pv;
    logic [W-1:0] pd [L];
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            for (int k = 0; k < L; k++) pd[k] <= '0;
        end else begin
            pv    <= {pv[L-2:0], o_pipe_valid};
            pd[0] <= o_pipe_mc * {{WA{1'b0}}, o_pipe_mp};
            for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
        end
    end
    assign pipe_ready   = (pv[L-1] | inj_ready) & ~inj_drop;
    assign pipe_product = pd[L-1];

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard: every grant becomes an op due back LAT cycles later, in order.
    typedef struct { int due; int idx; logic [W-1:0] prod; } op_t;
    op_t          q[$];
    int           m_ptr = 0, ew;
    logic [N-1:0] eg;
    logic         m_err = 1'b0, m_pv = 1'b0, tag_due;
    logic [W-1:0] m_mc = '0, m_last = '0;
    logic [WB-1:0] m_mp = '0;
    logic [W-1:0] last_data [N];
    int           gcyc[$], rcyc[$];
    logic [N-1:0] gval[$], rval[$];

    always @(negedge clk) begin
        if (chk_on) begin
            eg = '0;
            ew = 0;
            if (!rst && en)
                for (int k = 0; k < N; k++)
                    if (eg == '0 && ((req >> ((m_ptr + k) % N)) & 1) != 0) begin
                        ew = (m_ptr + k) % N;
                        eg = N'(1) << ew;
                    end
            chk("gnt", o_gnt, eg);
            chk("pipe_valid", o_pipe_valid, m_pv);
            chk("pipe_multiplicand", o_pipe_mc, m_mc);
            chk("pipe_multiplier", o_pipe_mp, m_mp);
            chk("busy", o_busy, q.size() != 0);
            chk("err", o_err, m_err);
            if (q.size() != 0 && q[0].due == cyc) begin
                chk("rsp_valid", o_rsp_valid, N'(1) << q[0].idx);
                chk("rsp_data", o_rsp_data, q[0].prod);
                m_last = q[0].prod;
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", o_rsp_valid, 0);
                chk("rsp_hold", o_rsp_data, m_last);
            end
            if (o_gnt != 0) begin gcyc.push_back(cyc); gval.push_back(o_gnt); end
            if (o_rsp_valid != 0) begin
                rcyc.push_back(cyc); rval.push_back(o_rsp_valid);
                for (int k = 0; k < N; k++)
                    if (((o_rsp_valid >> k) & 1) != 0) last_data[k] = o_rsp_data;
            end
            // Pipe output versus the op expected at the end of the line this cycle.
            tag_due = q.size() != 0 && q[0].due == cyc + 1;
            if (pipe_ready != tag_due) m_err = 1'b1;
            if (tag_due && !pipe_ready) void'(q.pop_front());
            m_pv = (eg != 0);
            if (eg != 0) begin
                m_mc = W'(ra[ew*WA +: WA]);
                m_mp = rb[ew*WB +: WB];
                q.push_back('{cyc + LAT, ew, W'(ra[ew*WA +: WA]) * W'(rb[ew*WB +: WB])});
                m_ptr = (ew + 1) % N;
            end else begin
                m_mc = '0;
                m_mp = '0;
            end
            if (rst) begin
                q.delete();
                m_ptr = 0; m_err = 1'b0; m_pv = 1'b0;
                m_mc = '0; m_mp = '0; m_last = '0;
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic set_op(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        ra[i*WA +: WA] = a;
        rb[i*WB +: WB] = b;
    endtask

    task automatic clear_logs();
        gcyc.delete(); gval.delete(); rcyc.delete(); rval.delete();
    endtask

    // Hold each request until granted, as the requester contract demands.
    task automatic serve(input logic [N-1:0] m);
        logic [N-1:0] g;
        int n = 0;
        req = m;
        while (req != 0 && n < 50) begin
            @(negedge clk);
            g = o_gnt;
            tick();
            req = req & ~g;
            n++;
        end
        chk("serve_done", req, 0);
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) last_data[k] = '1;
        rst = 1'b1;
        tick(); tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_gnt", o_gnt, 0);
        chk("reset_rsp_valid", o_rsp_valid, 0);
        chk("reset_rsp_data", o_rsp_data, 0);
        chk("reset_pipe", {o_pipe_valid, o_pipe_mc, o_pipe_mp}, 0);
        chk("reset_busy_err", {o_busy, o_err}, 0);
        tick();
        rst = 1'b0; en = 1'b1;

        // All four at once: ascending grants from ptr 0, responses in the same order.
        clear_logs();
        for (int k = 0; k < N; k++) set_op(k, WA'(k + 2), WB'(k + 10));
        serve(4'b1111);
        repeat (22) tick();
        chk("burst_ngnt", gval.size(), 4);
        chk("burst_nrsp", rcyc.size(), 4);
        for (int k = 0; k < 4 && k < gval.size() && k < rcyc.size(); k++) begin
            chk("burst_gnt_order", gval[k], 4'b0001 << k);
            chk("burst_rsp_order", rval[k], 4'b0001 << k);
            chk("burst_rsp_latency", rcyc[k] - gcyc[0], 18 + k);
        end

        // Single op: 3*5 on requester 1, 18 cycles grant to response.
        clear_logs();
        set_op(1, 16'd3, 16'd5);
        serve(4'b0010);
        repeat (20) tick();
        @(negedge clk);
        chk("single_nrsp", rcyc.size(), 1);
        if (rcyc.size() == 1 && gcyc.size() == 1) begin
            chk("single_gnt", gval[0], 4'b0010);
            chk("single_rsp", rval[0], 4'b0010);
            chk("single_latency", rcyc[0] - gcyc[0], 18);
        end
        chk("single_data", last_data[1], 32'd15);
        chk("single_busy_drained", o_busy, 0);
        tick();

        // Rotation: ptr is 2 here, so 0101 held alternates 0100/0001 (wrap after ptr 3).
        clear_logs();
        req = 4'b0101;
        repeat (6) tick();
        req = '0;
        chk("rot_ngnt", gval.size(), 6);
        for (int k = 0; k < 6 && k < gval.size(); k++)
            chk("rot_gnt", gval[k], (k % 2 == 0) ? 4'b0100 : 4'b0001);
        repeat (20) tick();

        // A lone continuous requester is granted every cycle.
        clear_logs();
        req = 4'b0010;
        repeat (4) tick();
        req = '0;
        chk("cont_ngnt", gval.size(), 4);
        for (int k = 0; k < gval.size(); k++) chk("cont_gnt", gval[k], 4'b0010);
        repeat (20) tick();

        // Operand extremes.
        set_op(0, 16'hFFFF, 16'hFFFF);
        set_op(1, 16'h0000, 16'h1234);
        set_op(2, 16'h1234, 16'h0000);
        set_op(3, 16'd1000, 16'd1000);
        serve(4'b1111);
        repeat (22) tick();
        chk("max_product", last_data[0], 32'hFFFE0001);
        chk("zero_a_product", last_data[1], 32'h0);
        chk("zero_b_product", last_data[2], 32'h0);
        chk("dec_product", last_data[3], 32'd1000000);

        // Enable drops mid-burst: no grants while low, earlier ops still drain.
        clear_logs();
        for (int k = 0; k < N; k++) set_op(k, WA'(100 + k), WB'(7));
        req = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            logic [N-1:0] g;
            @(negedge clk);
            g = o_gnt;
            tick();
            req = req & ~g;
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("enable_low_gnt", o_gnt, 0);
            tick();
        end
        repeat (18) tick();
        @(negedge clk);
        chk("enable_low_drained", o_busy, 0);
        chk("enable_low_nrsp", rcyc.size(), 2);
        tick();
        en = 1'b1;
        serve(req);
        repeat (22) tick();

        // Stray pipe_ready with nothing in flight: err sets and sticks.
        tick();
        inj_ready = 1'b1;
        tick();
        inj_ready = 1'b0;
        @(negedge clk);
        chk("err_set", o_err, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("err_sticky", o_err, 1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", o_err, 0);
        tick();

        // Valid tag with no pipe_ready: err sets and that op never responds.
        clear_logs();
        set_op(0, 16'd7, 16'd9);
        serve(4'b0001);
        repeat (16) tick();
        inj_drop = 1'b1;
        tick();
        inj_drop = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("drop_err", o_err, 1);
        chk("drop_nrsp", rcyc.size(), 0);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;

        // Reset with five ops in flight: all discarded, nothing comes back.
        serve(4'b1111);
        serve(4'b0001);
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("midrst_err", o_err, 0);
        chk("midrst_busy", o_busy, 0);
        repeat (25) tick();
        chk("midrst_nrsp", rcyc.size(), 0);
        chk("midrst_err_after", o_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
